// File: rtl/sc_statemachine_pointtype_if.sv
// sc_statemachine_pointtype_if: button inputs, register feedback and control pulses of the point-type FSM.
interface sc_statemachine_pointtype_if #(parameter int DATAWIDTH = 8);
    logic                 SC_STATEMACHINEPOINTTYPE_left_InLow;
    logic                 SC_STATEMACHINEPOINTTYPE_right_InLow;
    logic                 SC_STATEMACHINEPOINTTYPE_load_InLow;
    logic                 SC_STATEMACHINEPOINTTYPE_clear_InLow;
    logic [DATAWIDTH-1:0] SC_STATEMACHINEPOINTTYPE_pointtype_InBUS;
    logic                 SC_STATEMACHINEPOINTTYPE_clear_OutLow;
    logic                 SC_STATEMACHINEPOINTTYPE_load_OutLow;
    logic [1:0]           SC_STATEMACHINEPOINTTYPE_shiftselection_Out;
    logic [2:0]           SC_STATEMACHINEPOINTTYPE_state_Out;
    modport master (
        output SC_STATEMACHINEPOINTTYPE_left_InLow, SC_STATEMACHINEPOINTTYPE_right_InLow,
               SC_STATEMACHINEPOINTTYPE_load_InLow, SC_STATEMACHINEPOINTTYPE_clear_InLow,
               SC_STATEMACHINEPOINTTYPE_pointtype_InBUS,
        input  SC_STATEMACHINEPOINTTYPE_clear_OutLow, SC_STATEMACHINEPOINTTYPE_load_OutLow,
               SC_STATEMACHINEPOINTTYPE_shiftselection_Out, SC_STATEMACHINEPOINTTYPE_state_Out
    );
    modport slave (
        input  SC_STATEMACHINEPOINTTYPE_left_InLow, SC_STATEMACHINEPOINTTYPE_right_InLow,
               SC_STATEMACHINEPOINTTYPE_load_InLow, SC_STATEMACHINEPOINTTYPE_clear_InLow,
               SC_STATEMACHINEPOINTTYPE_pointtype_InBUS,
        output SC_STATEMACHINEPOINTTYPE_clear_OutLow, SC_STATEMACHINEPOINTTYPE_load_OutLow,
               SC_STATEMACHINEPOINTTYPE_shiftselection_Out, SC_STATEMACHINEPOINTTYPE_state_Out
    );
endinterface

// File: rtl/sc_statemachine_pointtype.sv
// sc_statemachine_pointtype: turns raw push-buttons into one-cycle clear/load/shift pulses for the point-type register.
module sc_statemachine_pointtype #(
    parameter int DATAWIDTH    = 8,
    parameter int REPEAT_TICKS = 25000000,
    parameter bit WRAP_EN      = 1'b1
) (
    input logic SC_STATEMACHINEPOINTTYPE_CLOCK_50,
    input logic SC_STATEMACHINEPOINTTYPE_RESET_InLow,
    sc_statemachine_pointtype_if.slave bus
);
    localparam int CW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
    typedef enum logic [2:0] {
        RESET_0 = 3'd0, CLEAR_0 = 3'd1, IDLE_0 = 3'd2, LEFT_0 = 3'd3,
        RIGHT_0 = 3'd4, LOAD_0 = 3'd5, HOLD_0 = 3'd6
    } state_t;
    typedef enum logic [1:0] {HELD_NONE, HELD_LEFT, HELD_RIGHT} held_t;
    state_t stateReg, stateNext;
    held_t heldReg, heldNext;
    logic [CW-1:0] cntReg, cntNext;
    logic [3:0] rawBtn, sync1, sync2, sync2d, press;
    logic allowLeft, allowRight;
    // Button order in the vectors: {clear, load, right, left}
    assign rawBtn = {bus.SC_STATEMACHINEPOINTTYPE_clear_InLow, bus.SC_STATEMACHINEPOINTTYPE_load_InLow,
                     bus.SC_STATEMACHINEPOINTTYPE_right_InLow, bus.SC_STATEMACHINEPOINTTYPE_left_InLow};
    assign press = ~sync2 & sync2d;
    assign allowLeft = WRAP_EN || !bus.SC_STATEMACHINEPOINTTYPE_pointtype_InBUS[DATAWIDTH-1];
    assign allowRight = WRAP_EN || !bus.SC_STATEMACHINEPOINTTYPE_pointtype_InBUS[0];
    always_ff @(posedge SC_STATEMACHINEPOINTTYPE_CLOCK_50 or negedge SC_STATEMACHINEPOINTTYPE_RESET_InLow) begin
        if (!SC_STATEMACHINEPOINTTYPE_RESET_InLow) begin
            stateReg <= RESET_0;
            heldReg <= HELD_NONE;
            cntReg <= '0;
            sync1 <= '1;
            sync2 <= '1;
            sync2d <= '1;
        end else begin
            stateReg <= stateNext;
            heldReg <= heldNext;
            cntReg <= cntNext;
            sync1 <= rawBtn;
            sync2 <= sync1;
            sync2d <= sync2;
        end
    end
    always_comb begin
        stateNext = stateReg;
        heldNext = heldReg;
        cntNext = '0;
        case (stateReg)
            RESET_0: stateNext = CLEAR_0;
            CLEAR_0, LOAD_0: begin
                stateNext = HOLD_0;
                heldNext = HELD_NONE;
            end
            LEFT_0: begin
                stateNext = HOLD_0;
                heldNext = HELD_LEFT;
            end
            RIGHT_0: begin
                stateNext = HOLD_0;
                heldNext = HELD_RIGHT;
            end
            IDLE_0: begin
                heldNext = HELD_NONE;
                if (press[3]) stateNext = CLEAR_0;
                else if (press[2]) stateNext = LOAD_0;
                else if (&press[1:0]) stateNext = HOLD_0;
                else if (press[0]) stateNext = allowLeft ? LEFT_0 : HOLD_0;
                else if (press[1]) stateNext = allowRight ? RIGHT_0 : HOLD_0;
            end
            HOLD_0: begin
                // Auto-repeat only while the direction that caused this hold is still down
                if (&sync2) stateNext = IDLE_0;
                else if ((heldReg == HELD_LEFT && !sync2[0]) || (heldReg == HELD_RIGHT && !sync2[1])) begin
                    if (cntReg == CW'(REPEAT_TICKS - 1)) begin
                        if (heldReg == HELD_LEFT ? allowLeft : allowRight)
                            stateNext = (heldReg == HELD_LEFT) ? LEFT_0 : RIGHT_0;
                    end else cntNext = cntReg + 1'b1;
                end else cntNext = cntReg;
            end
            default: stateNext = RESET_0;
        endcase
    end
    assign bus.SC_STATEMACHINEPOINTTYPE_clear_OutLow = stateReg != CLEAR_0;
    assign bus.SC_STATEMACHINEPOINTTYPE_load_OutLow = stateReg != LOAD_0;
    assign bus.SC_STATEMACHINEPOINTTYPE_shiftselection_Out = (stateReg == LEFT_0) ? 2'b01 : (stateReg == RIGHT_0) ? 2'b10 : 2'b00;
    assign bus.SC_STATEMACHINEPOINTTYPE_state_Out = stateReg;
endmodule
